// File: rtl/pll_clock_monitor.sv
// Multi-channel PLL output lock monitor: counts synchronised channel edges per window and
// declares lock / sticky fault. Optional capture readback behind macro PLL_MON_CAPTURE_EN.

module pll_mon_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chan_in,
    input  logic             clear,
    input  logic             count_en,
    input  logic             reload,
    output logic [CNT_W-1:0] count
);
    logic [2:0]       sync_q;
    logic             pulse;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // sync_q[1] is the synchronised level, sync_q[2] its one-cycle delay
    assign pulse = sync_q[1] & ~sync_q[2];
    assign count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (reload)
            cnt_d = CNT_W'(pulse);
        else if (count_en && pulse && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], chan_in};
            cnt_q  <= cnt_d;
        end
    end
endmodule

module pll_clock_monitor #(
    parameter int                          CHANNELS     = 6,
    parameter int                          CNT_W        = 16,
    parameter int                          WINDOW       = 256,
    parameter logic [CHANNELS*CNT_W-1:0]   EXPECTED     = {CHANNELS{16'd16}},
    parameter int                          TOL          = 1,
    parameter int                          LOCK_WINDOWS = 2
`ifdef PLL_MON_CAPTURE_EN
    , parameter int                        SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pll_locked,
    input  logic [CHANNELS-1:0] chan_in,
`ifdef PLL_MON_CAPTURE_EN
    input  logic [SEL_W-1:0]    sel,
    output logic [CNT_W-1:0]    meas_count,
`endif
    output logic [CHANNELS-1:0] chan_ok,
    output logic                all_locked,
    output logic                fault,
    output logic [1:0]          state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [1:0] S_EVAL = 2'd3;

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int GR_W  = $clog2(LOCK_WINDOWS + 1);
    localparam logic [CNT_W:0] TOL_V = (CNT_W+1)'(TOL);

    logic [1:0]                       lock_q;
    logic                             lock_s, lock_lost;
    logic [1:0]                       state_q, state_d;
    logic [WIN_W-1:0]                 win_q, win_d;
    logic [GR_W-1:0]                  good_q, good_d;
    logic [CHANNELS-1:0]              chan_ok_q, chan_ok_d, ok_w;
    logic                             locked_q, locked_d, fault_q, fault_d;
    logic                             ch_clear;
    logic [CHANNELS-1:0][CNT_W-1:0]   cnt_w;

    assign lock_s    = lock_q[1];
    assign lock_lost = ((state_q == S_MEAS) || (state_q == S_EVAL)) && !lock_s;
    assign ch_clear  = !enable || lock_lost || (state_q == S_IDLE) || (state_q == S_WAIT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam logic [CNT_W-1:0] EXP_I = EXPECTED[i*CNT_W +: CNT_W];
        logic [CNT_W:0] diff;

        pll_mon_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .chan_in  (chan_in[i]),
            .clear    (ch_clear),
            .count_en (state_q == S_MEAS),
            .reload   (state_q == S_EVAL),
            .count    (cnt_w[i])
        );

        // one extra bit keeps the absolute difference from wrapping
        assign diff = (cnt_w[i] >= EXP_I) ? ({1'b0, cnt_w[i]} - {1'b0, EXP_I})
                                          : ({1'b0, EXP_I} - {1'b0, cnt_w[i]});
        assign ok_w[i] = (diff <= TOL_V);
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        good_d    = good_q;
        chan_ok_d = chan_ok_q;
        locked_d  = locked_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: begin
                chan_ok_d = '0;
                locked_d  = 1'b0;
                fault_d   = 1'b0;
                good_d    = '0;
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                win_d = '0;
                if (lock_s) state_d = S_MEAS;
            end
            S_MEAS: begin
                win_d = win_q + WIN_W'(1);
                if (win_q == WIN_W'(WINDOW - 1)) state_d = S_EVAL;
            end
            default: begin
                chan_ok_d = ok_w;
                if (&ok_w) begin
                    if (good_q != GR_W'(LOCK_WINDOWS)) good_d = good_q + GR_W'(1);
                end else begin
                    good_d = '0;
                end
                locked_d = (good_d == GR_W'(LOCK_WINDOWS));
                if (locked_q && !(&ok_w)) fault_d = 1'b1;
                win_d   = '0;
                state_d = S_MEAS;
            end
        endcase
        if (lock_lost) begin
            state_d   = S_WAIT;
            win_d     = '0;
            good_d    = '0;
            chan_ok_d = '0;
            locked_d  = 1'b0;
            fault_d   = fault_q | locked_q;
        end
        // disable overrides lock loss and clears the sticky fault
        if (!enable) begin
            state_d   = S_IDLE;
            win_d     = '0;
            good_d    = '0;
            chan_ok_d = '0;
            locked_d  = 1'b0;
            fault_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= '0;
            state_q   <= S_IDLE;
            win_q     <= '0;
            good_q    <= '0;
            chan_ok_q <= '0;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            lock_q    <= {lock_q[0], pll_locked};
            state_q   <= state_d;
            win_q     <= win_d;
            good_q    <= good_d;
            chan_ok_q <= chan_ok_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
        end
    end

    assign chan_ok    = chan_ok_q;
    assign all_locked = locked_q;
    assign fault      = fault_q;
    assign state      = state_q;

`ifdef PLL_MON_CAPTURE_EN
    logic [CHANNELS-1:0][CNT_W-1:0] cap_q;
    logic [CNT_W-1:0]               meas_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q  <= '0;
            meas_q <= '0;
        end else begin
            if (state_q == S_IDLE)      cap_q <= '0;
            else if (state_q == S_EVAL) cap_q <= cnt_w;
            meas_q <= (32'(sel) < CHANNELS) ? cap_q[sel] : '0;
        end
    end

    assign meas_count = meas_q;
`endif
endmodule

// File: tb/tb_pll_clock_monitor.sv
// Scoreboard bench for pll_clock_monitor: per-window edge counts are chosen by the bench and
// the expected window result is derived from the lock/fault rules.
module tb_pll_clock_monitor;
    localparam int CH   = 6;
    localparam int CW   = 16;
    localparam int WIN  = 256;
    localparam int EXPV = 16;
    localparam int TOL  = 1;
    localparam int LW   = 2;

    typedef int kv_t[CH];
    typedef struct {
        logic [CH-1:0] ok;
        logic          locked;
        logic          fault;
        int            cap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, enable, pll_locked;
    logic [CH-1:0] chan_in;
    logic [CH-1:0] chan_ok;
    logic          all_locked, fault;
    logic [1:0]    state;
`ifdef PLL_MON_CAPTURE_EN
    logic [2:0]    sel = 3'd0;
    logic [CW-1:0] meas_count;
`endif

    exp_t sbq[$];
    int   checks = 0, failures = 0;
    int   m_good = 0;
    bit   m_locked = 0, m_fault = 0;
    bit   mon_en = 0, mon_pe = 0;
    exp_t mon_e;

    always #5 clk = ~clk;

    pll_clock_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pll_locked (pll_locked),
        .chan_in    (chan_in),
`ifdef PLL_MON_CAPTURE_EN
        .sel        (sel),
        .meas_count (meas_count),
`endif
        .chan_ok    (chan_ok),
        .all_locked (all_locked),
        .fault      (fault),
        .state      (state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outcome of one window from its edge counts.
    task automatic model_push(input kv_t k, input int s);
        exp_t e;
        int   d;
        for (int i = 0; i < CH; i++) begin
            d = (k[i] > EXPV) ? k[i] - EXPV : EXPV - k[i];
            e.ok[i] = (d <= TOL);
        end
        if (m_locked && !(&e.ok)) m_fault = 1;
        if (&e.ok) m_good = (m_good + 1 > LW) ? LW : m_good + 1;
        else       m_good = 0;
        m_locked = (m_good == LW);
        e.locked = m_locked;
        e.fault  = m_fault;
        e.cap    = (s < CH) ? k[s] : 0;
        sbq.push_back(e);
    endtask

    task automatic run_window(input kv_t k);
        logic [1:0] last;
        bit         found = 0;
        int         s, maxk = 0;
        last = state;
        for (int n = 0; n < 3 * WIN; n++) begin
            @(negedge clk);
            if (state == 2'd2 && last != 2'd2) begin found = 1; break; end
            last = state;
        end
        chk("window_start", 32'(found), 32'd1);
        if (!found) return;
        s = $urandom_range(0, 7);
        model_push(k, s);
        repeat (4) @(negedge clk);
`ifdef PLL_MON_CAPTURE_EN
        sel = 3'(s);
`endif
        repeat (4) @(negedge clk);
        for (int i = 0; i < CH; i++) if (k[i] > maxk) maxk = k[i];
        for (int p = 0; p < maxk; p++) begin
            for (int i = 0; i < CH; i++) chan_in[i] = (p < k[i]);
            repeat (2) @(negedge clk);
            chan_in = '0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 3 * WIN && sbq.size() != 0; n++) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_disable();
        drain();
        enable = 1'b0;
        @(negedge clk);
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_fault", 32'(fault), 32'd0);
        chk("dis_locked", 32'(all_locked), 32'd0);
        chk("dis_chan_ok", 32'(chan_ok), 32'd0);
        m_good = 0; m_locked = 0; m_fault = 0;
        enable = 1'b1;
    endtask

    function automatic kv_t fill(input int v);
        kv_t k;
        for (int i = 0; i < CH; i++) k[i] = v;
        return k;
    endfunction

    // Monitor: the cycle after each EVAL the registered results are compared.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) mon_pe = 0;
            else begin
                if (mon_pe) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_empty: got window result with no expected entry at %0t", $time);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("chan_ok", 32'(chan_ok), 32'(mon_e.ok));
                        chk("all_locked", 32'(all_locked), 32'(mon_e.locked));
                        chk("fault", 32'(fault), 32'(mon_e.fault));
`ifdef PLL_MON_CAPTURE_EN
                        @(negedge clk);
                        chk("meas_count", 32'(meas_count), 32'(mon_e.cap));
`endif
                    end
                end
                mon_pe = (state == 2'd3);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        kv_t  k;
        bit   found;
        rst_n = 1'b0; enable = 1'b0; pll_locked = 1'b0; chan_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_chan_ok", 32'(chan_ok), 32'd0);
        chk("rst_locked", 32'(all_locked), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        // reset in the middle of a measurement with channels toggling
        rst_n = 1'b1; enable = 1'b1; pll_locked = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (t % 8 == 0) chan_in = ~chan_in;
        end
        chk("pre_rst_meas", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_chan_ok", 32'(chan_ok), 32'd0);
        chk("async_rst_locked", 32'(all_locked), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        chan_in = '0; enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", 32'(state), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("to_wait", 32'(state), 32'd1);
        mon_en = 1;

        // nominal lock, then tolerance boundary on channel 0 (18 edges while locked -> fault)
        run_window(fill(16));
        run_window(fill(16));
        k = fill(16); k[0] = 17; run_window(k);
        k[0] = 18; run_window(k);
        run_window(fill(16));
        do_disable();

        // channel 2 at double frequency never locks
        k = fill(16); k[2] = 32;
        repeat (3) run_window(k);
        run_window(fill(16));
        run_window(fill(16));

        // degradation after lock: channel 5 stops, then resumes
        k = fill(16); k[5] = 0; run_window(k);
        run_window(fill(16));
        run_window(fill(16));
        do_disable();

        // lock loss while locked
        run_window(fill(16));
        run_window(fill(16));
        drain();
        pll_locked = 1'b0;
        found = 0;
        for (int n = 0; n < 6 && !found; n++) begin
            @(negedge clk);
            if (state == 2'd1) found = 1;
        end
        m_fault = m_fault | m_locked; m_locked = 0; m_good = 0;
        chk("lockloss_wait", 32'(found), 32'd1);
        chk("lockloss_locked", 32'(all_locked), 32'd0);
        chk("lockloss_fault", 32'(fault), 32'(m_fault));
        chk("lockloss_chan_ok", 32'(chan_ok), 32'd0);
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        run_window(fill(16));
        run_window(fill(16));

        // randomized windows
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < CH; i++)
                k[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                                   : int'($urandom_range(13, 19));
            run_window(k);
        end
        do_disable();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
